// File: rtl/hyperram_arbiter.sv
// Two-master round-robin arbiter in front of a single HyperRAM controller port.
// Supports lock-held bursts bounded by MAX_HOLD and a response watchdog with abort.
module hyperram_arbiter #(
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic                m0_lock,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_sel,
    output logic                m0_ack,
    output logic                m0_err,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic                m1_lock,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_sel,
    output logic                m1_ack,
    output logic                m1_err,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_req,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_sel,
    output logic                s_abort,
    input  logic                s_ack,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          o_grant,
    output logic                o_busy
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q;     // last granted master, 0 = M0, 1 = M1
    logic              lock_q;      // owner_q asked to keep the grant at its last ack
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [15:0]       wd_q;
    logic              grant_go, grant_sel;
    logic              timeout_hit;
    logic              owner_req;

    assign timeout_hit = (wd_q == WD_LIMIT);
    assign owner_req   = owner_q ? m1_req : m0_req;
    assign o_busy      = (state_q != IDLE);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        grant_go  = 1'b0;
        grant_sel = owner_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                if (lock_q && owner_req && (hold_q < HOLD_MAX)) begin
                    grant_go  = 1'b1;
                    grant_sel = owner_q;
                    hold_d    = hold_q + HOLD_ONE;
                end else if (m0_req && m1_req) begin
                    grant_go  = 1'b1;
                    grant_sel = ~owner_q;
                    hold_d    = HOLD_ONE;
                end else if (m0_req || m1_req) begin
                    grant_go  = 1'b1;
                    grant_sel = m1_req;
                    if (m1_req != owner_q)
                        hold_d = HOLD_ONE;
                    else if (hold_q < HOLD_MAX)
                        hold_d = hold_q + HOLD_ONE;
                    else
                        hold_d = HOLD_MAX;
                end
                if (grant_go)
                    state_d = ACTIVE;
            end
            ACTIVE:  if (s_ack || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner_q  <= 1'b1;
            lock_q   <= 1'b0;
            hold_q   <= '0;
            wd_q     <= '0;
            s_req    <= 1'b0;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_sel    <= '0;
            s_abort  <= 1'b0;
            o_grant  <= 2'b00;
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
        end else begin
            m0_ack  <= 1'b0;
            m1_ack  <= 1'b0;
            m0_err  <= 1'b0;
            m1_err  <= 1'b0;
            s_abort <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_go) begin
                        owner_q <= grant_sel;
                        hold_q  <= hold_d;
                        wd_q    <= '0;
                        s_req   <= 1'b1;
                        o_grant <= grant_sel ? 2'b10 : 2'b01;
                        s_we    <= grant_sel ? m1_we    : m0_we;
                        s_addr  <= grant_sel ? m1_addr  : m0_addr;
                        s_wdata <= grant_sel ? m1_wdata : m0_wdata;
                        s_sel   <= grant_sel ? m1_sel   : m0_sel;
                    end
                end
                ACTIVE: begin
                    if (s_ack) begin
                        s_req <= 1'b0;
                        if (owner_q) begin
                            m1_rdata <= s_rdata;
                            m1_ack   <= 1'b1;
                            lock_q   <= m1_lock;
                        end else begin
                            m0_rdata <= s_rdata;
                            m0_ack   <= 1'b1;
                            lock_q   <= m0_lock;
                        end
                    end else if (timeout_hit) begin
                        s_req   <= 1'b0;
                        s_abort <= 1'b1;
                        m0_err  <= ~owner_q;
                        m1_err  <= owner_q;
                        lock_q  <= 1'b0;
                        hold_q  <= '0;
                    end else begin
                        wd_q <= wd_q + 16'd1;
                    end
                end
                RESP:    o_grant <= 2'b00;
                default: o_grant <= 2'b00;
            endcase
        end
    end
endmodule
